// File: rtl/result_pkg.sv
// rtl/result_pkg.sv - frame constants, serializer state type and frame byte mux for result_uart_tx
package result_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam int         NUM_BYTES = 9;
  localparam int         N_REG     = 12;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // snap = {r1, r2, r3, r4}; odd bytes carry the high nibble, even bytes the low byte
  function automatic logic [7:0] frame_byte(input logic [4*N_REG-1:0] snap,
                                            input logic [3:0]         idx);
    logic [7:0] b;
    case (idx)
      4'd1:    b = {4'h0, snap[47:44]};
      4'd2:    b = snap[43:36];
      4'd3:    b = {4'h0, snap[35:32]};
      4'd4:    b = snap[31:24];
      4'd5:    b = {4'h0, snap[23:20]};
      4'd6:    b = snap[19:12];
      4'd7:    b = {4'h0, snap[11:8]};
      4'd8:    b = snap[7:0];
      default: b = FRAME_HDR;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/result_uart_tx_if.sv
// rtl/result_uart_tx_if.sv - result inputs, trigger flag and serial line bundle
interface result_uart_tx_if;
  import result_pkg::*;

  logic [N_REG-1:0] r1;
  logic [N_REG-1:0] r2;
  logic [N_REG-1:0] r3;
  logic [N_REG-1:0] r4;
  logic             end_process;
  logic             tx;
  logic             busy;
  logic             done;

  modport master (output r1, r2, r3, r4, end_process, input tx, busy, done);
  modport slave  (input r1, r2, r3, r4, end_process, output tx, busy, done);

endinterface

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer with baud counter and load/ready handshake
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       ready,
  output logic       tx
);
  import result_pkg::*;

  localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          baud_last;

  assign baud_last = (baud == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    ready     = 1'b0;
    tx        = 1'b1;
    baud_n    = (state == IDLE || baud_last) ? '0 : baud + 1'b1;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (load) begin
          state_n = START;
          shreg_n = byte_in;
        end
      end
      START: begin
        tx = 1'b0;
        if (baud_last) begin
          state_n   = DATA;
          bit_idx_n = '0;
        end
      end
      DATA: begin
        tx = shreg[0];
        if (baud_last) begin
          shreg_n = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end
      end
      STOP: begin
        // Accepting the next byte on the last stop cycle keeps bytes back-to-back
        if (baud_last) begin
          ready = 1'b1;
          if (load) begin
            state_n = START;
            shreg_n = byte_in;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/result_uart_tx.sv
// rtl/result_uart_tx.sv - snapshots r1..r4 on end_process rising edge and sends a 9-byte UART frame
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int N_REG        = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  result_uart_tx_if.slave  bus
);
  import result_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(NUM_BYTES - 1);

  logic               ep_q;
  logic               busy_q;
  logic               done_q;
  logic [3:0]         byte_idx;
  logic [4*N_REG-1:0] snap;
  logic               trigger;
  logic               ready;
  logic               load_next;
  logic               frame_end;
  logic               load;
  logic [7:0]         byte_in;

  assign trigger   = bus.end_process & ~ep_q & ~busy_q;
  assign load_next = busy_q & ready & (byte_idx != LAST_IDX);
  assign frame_end = busy_q & ready & (byte_idx == LAST_IDX);
  assign load      = trigger | load_next;
  // The header goes out on the trigger edge itself, before the snapshot register is valid
  assign byte_in   = trigger ? FRAME_HDR : frame_byte(snap, byte_idx + 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ep_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      byte_idx <= '0;
      snap     <= '0;
    end else begin
      ep_q   <= bus.end_process;
      done_q <= frame_end;
      if (trigger) begin
        snap     <= {bus.r1, bus.r2, bus.r3, bus.r4};
        busy_q   <= 1'b1;
        byte_idx <= '0;
      end else if (load_next) begin
        byte_idx <= byte_idx + 4'd1;
      end else if (frame_end) begin
        busy_q <= 1'b0;
      end
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .byte_in (byte_in),
    .ready   (ready),
    .tx      (bus.tx)
  );

  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
